// File: rtl/ccu_pkg.sv
// Shared ACE snoop definitions: CRRESP bit positions, ACSNOOP codes, state-update ops,
// default channel structs and the snoop response decode.
package ccu_pkg;

  localparam int unsigned AceAddrWidth = 64;
  localparam int unsigned AceDataWidth = 128;

  localparam int unsigned CR_DT  = 0;
  localparam int unsigned CR_ERR = 1;
  localparam int unsigned CR_PD  = 2;
  localparam int unsigned CR_IS  = 3;
  localparam int unsigned CR_WU  = 4;

  localparam logic [3:0] SNP_READ_ONCE        = 4'b0000;
  localparam logic [3:0] SNP_READ_SHARED      = 4'b0001;
  localparam logic [3:0] SNP_READ_CLEAN       = 4'b0010;
  localparam logic [3:0] SNP_READ_NOT_SHR_DIRTY = 4'b0011;
  localparam logic [3:0] SNP_READ_UNIQUE      = 4'b0111;
  localparam logic [3:0] SNP_CLEAN_SHARED     = 4'b1000;
  localparam logic [3:0] SNP_CLEAN_INVALID    = 4'b1001;
  localparam logic [3:0] SNP_MAKE_INVALID     = 4'b1101;

  typedef enum logic [1:0] {
    UPD_NONE              = 2'd0,
    UPD_INVALIDATE        = 2'd1,
    UPD_MAKE_CLEAN_SHARED = 2'd2
  } snoop_upd_op_e;

  typedef struct packed {
    logic [AceAddrWidth-1:0] addr;
    logic [3:0]              snoop;
    logic [2:0]              prot;
  } ace_ac_chan_t;

  typedef struct packed {
    logic [AceDataWidth-1:0] data;
    logic                    last;
  } ace_cd_chan_t;

  typedef struct packed {
    logic         ac_valid;
    ace_ac_chan_t ac;
    logic         cr_ready;
    logic         cd_ready;
  } snoop_req_default_t;

  typedef struct packed {
    logic         ac_ready;
    logic         cr_valid;
    logic [4:0]   cr_resp;
    logic         cd_valid;
    ace_cd_chan_t cd;
  } snoop_resp_default_t;

  typedef struct packed {
    logic [4:0]    cr_resp;
    logic          dt;
    logic          upd;
    snoop_upd_op_e upd_op;
  } snoop_decision_t;

  function automatic logic snoop_legal(input logic [3:0] snoop);
    case (snoop)
      SNP_READ_ONCE, SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NOT_SHR_DIRTY,
      SNP_READ_UNIQUE, SNP_CLEAN_SHARED, SNP_CLEAN_INVALID, SNP_MAKE_INVALID: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic snoop_decision_t snoop_decode(input logic [3:0] snoop, input logic hit,
                                                   input logic dirty, input logic shared);
    snoop_decision_t d;
    d = '0;
    d.upd_op = UPD_NONE;
    if (!snoop_legal(snoop)) begin
      d.cr_resp[CR_ERR] = 1'b1;
    end else if (hit) begin
      d.cr_resp[CR_WU] = ~shared;
      case (snoop)
        SNP_READ_SHARED: begin
          d.dt = 1'b1;
          d.cr_resp[CR_IS] = 1'b1;
          d.cr_resp[CR_PD] = dirty;
          d.upd = 1'b1;
          d.upd_op = UPD_MAKE_CLEAN_SHARED;
        end
        SNP_READ_UNIQUE, SNP_CLEAN_INVALID: begin
          d.dt = 1'b1;
          d.cr_resp[CR_PD] = dirty;
          d.upd = 1'b1;
          d.upd_op = UPD_INVALIDATE;
        end
        SNP_CLEAN_SHARED: begin
          d.dt = dirty;
          d.cr_resp[CR_PD] = dirty;
          d.cr_resp[CR_IS] = 1'b1;
          d.upd = dirty;
          d.upd_op = UPD_MAKE_CLEAN_SHARED;
        end
        SNP_MAKE_INVALID: begin
          d.upd = 1'b1;
          d.upd_op = UPD_INVALIDATE;
        end
        default: begin
          // ReadOnce, ReadClean, ReadNotSharedDirty: copy out, keep the line as is
          d.dt = 1'b1;
          d.cr_resp[CR_IS] = 1'b1;
        end
      endcase
      d.cr_resp[CR_DT] = d.dt;
    end
    return d;
  endfunction

endpackage

// File: rtl/ccu_cd_serializer.sv
// Holds one cache line and streams it on the CD channel, least significant beat first.
module ccu_cd_serializer
  import ccu_pkg::*;
#(
  parameter int unsigned LineWidth = 512,
  parameter int unsigned BeatWidth = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [LineWidth-1:0] line_i,
  input  logic                 start_i,
  input  logic                 cd_ready_i,
  output logic                 cd_valid_o,
  output logic [BeatWidth-1:0] cd_data_o,
  output logic                 cd_last_o,
  output logic                 done_o
);

  localparam int unsigned NumBeats = LineWidth / BeatWidth;
  localparam int unsigned CntW     = (NumBeats > 1) ? $clog2(NumBeats) : 1;

  logic [LineWidth-1:0] line_q, line_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 active_q, active_d;

  always_comb begin
    line_d     = line_q;
    cnt_d      = cnt_q;
    active_d   = active_q;
    done_o     = 1'b0;
    cd_valid_o = active_q;
    cd_last_o  = (cnt_q == CntW'(NumBeats - 1));
    cd_data_o  = line_q[BeatWidth * int'(cnt_q) +: BeatWidth];
    if (load_i) line_d = line_i;
    if (start_i) active_d = 1'b1;
    if (active_q && cd_ready_i) begin
      if (cd_last_o) begin
        active_d = 1'b0;
        cnt_d    = '0;
        done_o   = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      line_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      line_q   <= line_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/ccu_snoop_responder.sv
// Cache-side ACE snoop responder: looks up the snooped line, answers on CR, streams data on CD
// and issues the resulting line-state update. One snoop in flight at a time.
module ccu_snoop_responder
  import ccu_pkg::*;
#(
  parameter int unsigned DcacheLineWidth = 512,
  parameter int unsigned AxiDataWidth    = AceDataWidth,
  parameter int unsigned AxiAddrWidth    = AceAddrWidth,
  parameter type         snoop_req_t     = snoop_req_default_t,
  parameter type         snoop_resp_t    = snoop_resp_default_t
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  snoop_req_t                 snoop_req_i,
  output snoop_resp_t                snoop_resp_o,
  output logic                       lkp_valid_o,
  input  logic                       lkp_ready_i,
  output logic [AxiAddrWidth-1:0]    lkp_addr_o,
  input  logic                       lkp_rvalid_i,
  input  logic                       lkp_hit_i,
  input  logic                       lkp_dirty_i,
  input  logic                       lkp_shared_i,
  output logic                       data_req_o,
  input  logic                       data_gnt_i,
  input  logic                       data_rvalid_i,
  input  logic [DcacheLineWidth-1:0] data_rdata_i,
  output logic                       upd_valid_o,
  input  logic                       upd_ready_i,
  output snoop_upd_op_e              upd_op_o
);

  localparam int unsigned LineOffW = $clog2(DcacheLineWidth / 8);
  localparam logic [AxiAddrWidth-1:0] LineMask = {AxiAddrWidth{1'b1}} << LineOffW;

  typedef enum logic [2:0] {
    StIdle, StLkp, StLkpWait, StDataReq, StDataWait, StCr, StCd, StUpd
  } state_e;

  state_e                  state_q, state_d;
  logic [AxiAddrWidth-1:0] addr_q, addr_d;
  logic [3:0]              snoop_q, snoop_d;
  logic                    hit_q, hit_d, dirty_q, dirty_d, shared_q, shared_d;

  snoop_decision_t   dec, lkp_dec;
  logic              ac_ready, cr_valid;
  logic              ser_load, ser_start, ser_done, cd_valid, cd_last;
  logic [AxiDataWidth-1:0] cd_data;
  logic              unused_prot;

  assign unused_prot = ^snoop_req_i.ac.prot;

  assign dec     = snoop_decode(snoop_q, hit_q, dirty_q, shared_q);
  assign lkp_dec = snoop_decode(snoop_q, lkp_hit_i, lkp_dirty_i, lkp_shared_i);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    snoop_d     = snoop_q;
    hit_d       = hit_q;
    dirty_d     = dirty_q;
    shared_d    = shared_q;
    ac_ready    = 1'b0;
    cr_valid    = 1'b0;
    lkp_valid_o = 1'b0;
    data_req_o  = 1'b0;
    upd_valid_o = 1'b0;
    ser_load    = 1'b0;
    ser_start   = 1'b0;
    unique case (state_q)
      StIdle: begin
        ac_ready = 1'b1;
        if (snoop_req_i.ac_valid) begin
          addr_d   = AxiAddrWidth'(snoop_req_i.ac.addr) & LineMask;
          snoop_d  = snoop_req_i.ac.snoop;
          hit_d    = 1'b0;
          dirty_d  = 1'b0;
          shared_d = 1'b0;
          // Unknown snoops skip the lookup and answer with an error response
          state_d  = snoop_legal(snoop_req_i.ac.snoop) ? StLkp : StCr;
        end
      end
      StLkp: begin
        lkp_valid_o = 1'b1;
        if (lkp_ready_i) begin
          if (lkp_rvalid_i) begin
            hit_d    = lkp_hit_i;
            dirty_d  = lkp_dirty_i;
            shared_d = lkp_shared_i;
            state_d  = lkp_dec.dt ? StDataReq : StCr;
          end else begin
            state_d = StLkpWait;
          end
        end
      end
      StLkpWait: begin
        if (lkp_rvalid_i) begin
          hit_d    = lkp_hit_i;
          dirty_d  = lkp_dirty_i;
          shared_d = lkp_shared_i;
          state_d  = lkp_dec.dt ? StDataReq : StCr;
        end
      end
      StDataReq: begin
        data_req_o = 1'b1;
        if (data_gnt_i) state_d = StDataWait;
      end
      StDataWait: begin
        if (data_rvalid_i) begin
          ser_load = 1'b1;
          state_d  = StCr;
        end
      end
      StCr: begin
        cr_valid = 1'b1;
        if (snoop_req_i.cr_ready) begin
          if (dec.dt) begin
            ser_start = 1'b1;
            state_d   = StCd;
          end else if (dec.upd) begin
            state_d = StUpd;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StCd: begin
        if (ser_done) state_d = dec.upd ? StUpd : StIdle;
      end
      StUpd: begin
        upd_valid_o = 1'b1;
        if (upd_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      snoop_q  <= '0;
      hit_q    <= 1'b0;
      dirty_q  <= 1'b0;
      shared_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      snoop_q  <= snoop_d;
      hit_q    <= hit_d;
      dirty_q  <= dirty_d;
      shared_q <= shared_d;
    end
  end

  ccu_cd_serializer #(
    .LineWidth(DcacheLineWidth),
    .BeatWidth(AxiDataWidth)
  ) u_cd_serializer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (ser_load),
    .line_i    (data_rdata_i),
    .start_i   (ser_start),
    .cd_ready_i(snoop_req_i.cd_ready),
    .cd_valid_o(cd_valid),
    .cd_data_o (cd_data),
    .cd_last_o (cd_last),
    .done_o    (ser_done)
  );

  assign lkp_addr_o = addr_q;
  assign upd_op_o   = (state_q == StUpd) ? dec.upd_op : UPD_NONE;

  always_comb begin
    snoop_resp_o          = '0;
    snoop_resp_o.ac_ready = ac_ready & ~rst_i;
    snoop_resp_o.cr_valid = cr_valid;
    snoop_resp_o.cr_resp  = cr_valid ? dec.cr_resp : 5'b0;
    snoop_resp_o.cd_valid = cd_valid;
    snoop_resp_o.cd.data  = cd_data;
    snoop_resp_o.cd.last  = cd_last;
  end

endmodule
